// File: rtl/timer_pkg.sv
// Shared constants for the timer sequencer: register map, bit positions, FSM states.
package timer_pkg;

  localparam logic [1:0] ADDR_CTRL = 2'd0;
  localparam logic [1:0] ADDR_CMP  = 2'd1;
  localparam logic [1:0] ADDR_PSC  = 2'd2;
  localparam logic [1:0] ADDR_STAT = 2'd3;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_PER = 1;
  localparam int CTRL_IE  = 2;

  localparam int STAT_EXP = 0;
  localparam int STAT_RUN = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } state_t;

endpackage

// File: rtl/timer_prescale.sv
// Prescale counter: counts enabled cycles and emits a tick each time it reaches
// the active prescale value, then restarts from zero.
module timer_prescale
  import timer_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic [7:0] i_psc_act,
  output logic       o_tick
);

  logic [7:0] r_psc_cnt;
  logic       w_match;

  assign w_match = (r_psc_cnt == i_psc_act);
  assign o_tick  = i_en & w_match;

  // Prescale count: clear has priority, otherwise advance or wrap on a tick.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_psc_cnt <= 8'd0;
    end else if (i_clr) begin
      r_psc_cnt <= 8'd0;
    end else if (i_en) begin
      r_psc_cnt <= w_match ? 8'd0 : r_psc_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// APB-programmed timer sequencer: register file, IDLE/START/RUN FSM and
// count/compare logic producing trig, irq and busy.
module timer_ctrl
  import timer_pkg::*;
(
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       PSEL,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [1:0] PADDR,
  input  logic [7:0] PWDATA,
  output logic [7:0] PRDATA,
  output logic       PREADY,
  output logic       tick,
  output logic [7:0] count,
  output logic       trig,
  output logic       irq,
  output logic       busy
);

  state_t     r_state;
  state_t     w_state_next;
  logic [2:0] r_ctrl;
  logic [7:0] r_cmp;
  logic [7:0] r_psc;
  logic [7:0] r_cmp_act;
  logic [7:0] r_psc_act;
  logic [7:0] r_count;
  logic       r_trig;
  logic       r_exp;

  logic w_wr;
  logic w_wr_ctrl;
  logic w_wr_cmp;
  logic w_wr_psc;
  logic w_wr_stat;
  logic w_en_next;
  logic w_tick;
  logic w_expire;
  logic w_load_act;
  logic w_count_clr;
  logic w_count_inc;
  logic w_oneshot_done;
  logic w_psc_clr;
  logic w_psc_en;

  assign w_wr      = PSEL & PENABLE & PWRITE;
  assign w_wr_ctrl = w_wr & (PADDR == ADDR_CTRL);
  assign w_wr_cmp  = w_wr & (PADDR == ADDR_CMP);
  assign w_wr_psc  = w_wr & (PADDR == ADDR_PSC);
  assign w_wr_stat = w_wr & (PADDR == ADDR_STAT);

  // EN as it will be after this edge, so a software clear aborts without an extra cycle.
  assign w_en_next = w_wr_ctrl ? PWDATA[CTRL_EN] : r_ctrl[CTRL_EN];
  assign w_expire  = w_tick & (r_count == r_cmp_act);

  // The prescaler only runs in RUN and is zeroed whenever RUN is left or not entered.
  assign w_psc_en  = (r_state == RUN);
  assign w_psc_clr = (w_state_next != RUN);

  timer_prescale u_prescale (
    .i_clk     (PCLK),
    .i_rst_n   (PRESETn),
    .i_clr     (w_psc_clr),
    .i_en      (w_psc_en),
    .i_psc_act (r_psc_act),
    .o_tick    (w_tick)
  );

  // FSM state register.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  // Next state plus the load/clear/increment strobes for the count path.
  always_comb begin
    w_state_next   = r_state;
    w_load_act     = 1'b0;
    w_count_clr    = 1'b0;
    w_count_inc    = 1'b0;
    w_oneshot_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_en_next) w_state_next = START;
      end
      START: begin
        w_load_act   = 1'b1;
        w_count_clr  = 1'b1;
        w_state_next = w_en_next ? RUN : IDLE;
      end
      RUN: begin
        if (w_expire) begin
          // Expiry is always recorded; only periodic mode with EN still set reloads.
          if (r_ctrl[CTRL_PER] && w_en_next) begin
            w_load_act  = 1'b1;
            w_count_clr = 1'b1;
          end else begin
            w_state_next   = IDLE;
            w_oneshot_done = ~r_ctrl[CTRL_PER];
          end
        end else if (!w_en_next) begin
          w_state_next = IDLE;
        end else if (w_tick) begin
          w_count_inc = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Software-visible registers; one-shot completion clears EN over any same-edge write.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_ctrl <= 3'd0;
      r_cmp  <= 8'd0;
      r_psc  <= 8'd0;
      r_exp  <= 1'b0;
    end else begin
      if (w_wr_ctrl) r_ctrl <= PWDATA[2:0];
      if (w_oneshot_done) r_ctrl[CTRL_EN] <= 1'b0;
      if (w_wr_cmp) r_cmp <= PWDATA;
      if (w_wr_psc) r_psc <= PWDATA;
      // A new expiry wins over a simultaneous write-1-to-clear.
      if (w_expire) r_exp <= 1'b1;
      else if (w_wr_stat && PWDATA[STAT_EXP]) r_exp <= 1'b0;
    end
  end

  // Active copies, count and the one-cycle trigger pulse.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_cmp_act <= 8'd0;
      r_psc_act <= 8'd0;
      r_count   <= 8'd0;
      r_trig    <= 1'b0;
    end else begin
      if (w_load_act) begin
        r_cmp_act <= r_cmp;
        r_psc_act <= r_psc;
      end
      if (w_count_clr)      r_count <= 8'd0;
      else if (w_count_inc) r_count <= r_count + 8'd1;
      r_trig <= w_expire;
    end
  end

  // Read mux: zero unless a read is addressed to this block.
  always_comb begin
    PRDATA = 8'd0;
    if (PSEL && !PWRITE) begin
      case (PADDR)
        ADDR_CTRL: PRDATA = {5'd0, r_ctrl};
        ADDR_CMP:  PRDATA = r_cmp;
        ADDR_PSC:  PRDATA = r_psc;
        ADDR_STAT: PRDATA = {6'd0, busy, r_exp};
        default:   PRDATA = 8'd0;
      endcase
    end
  end

  assign PREADY = 1'b1;
  assign tick   = w_tick;
  assign count  = r_count;
  assign trig   = r_trig;
  assign irq    = r_exp & r_ctrl[CTRL_IE];
  assign busy   = (r_state != IDLE);

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: register table, one-shot table, and
// hand-timed periodic / collision / abort / reset sequences.
module tb_timer_ctrl;

  logic       PCLK = 1'b0;
  logic       PRESETn;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [1:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic       tick;
  logic [7:0] count;
  logic       trig;
  logic       irq;
  logic       busy;

  timer_ctrl dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .tick    (tick),
    .count   (count),
    .trig    (trig),
    .irq     (irq),
    .busy    (busy)
  );

  always #5 PCLK = ~PCLK;

  // Edge counter: the posedge that makes cyc == X is called edge X.
  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  int last_commit = 0;
  int tick_cnt = 0;
  int trig_obs[$];
  int trig_exp[$];

  typedef struct {
    string      name;
    logic [7:0] val;
  } sb_t;
  sb_t rd_q[$];

  typedef struct {
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] rexp;
  } reg_vec_t;

  typedef struct {
    logic [7:0] psc;
    logic [7:0] cmp;
  } os_vec_t;

  // Output monitor, sampled on the falling edge.
  always @(negedge PCLK) begin
    if (trig === 1'b1) trig_obs.push_back(cyc);
    if (tick === 1'b1) tick_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end else begin
      $display("ok   %s = %0d", nm, act);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge PCLK);
  endtask

  // Called at a falling edge with cyc == K; the write commits at edge K+2.
  task automatic apb_write(input logic [1:0] a, input logic [7:0] d);
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
    last_commit = cyc + 2;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [1:0] a, input logic [7:0] exp_v, input string nm);
    sb_t        e;
    logic [7:0] got;
    e.name = nm;
    e.val  = exp_v;
    rd_q.push_back(e);
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1;
    got = PRDATA;
    e = rd_q.pop_front();
    chk(e.name, {24'd0, got}, {24'd0, e.val});
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic compare_trigs(input string nm);
    int e;
    int o;
    while (trig_exp.size() > 0) begin
      e = trig_exp.pop_front();
      o = (trig_obs.size() > 0) ? trig_obs.pop_front() : -1;
      chk({nm, " trig cycle"}, o, e);
    end
    chk({nm, " extra trigs"}, trig_obs.size(), 0);
    trig_obs.delete();
  endtask

  reg_vec_t regv[5];
  os_vec_t  osv[3];
  int       c0;
  logic [31:0] rnd;

  initial begin
    regv[0] = '{addr: 2'd1, wdata: 8'hA5, rexp: 8'hA5};
    regv[1] = '{addr: 2'd2, wdata: 8'h3C, rexp: 8'h3C};
    regv[2] = '{addr: 2'd0, wdata: 8'hFE, rexp: 8'h06};
    regv[3] = '{addr: 2'd3, wdata: 8'hFF, rexp: 8'h00};
    regv[4] = '{addr: 2'd0, wdata: 8'h00, rexp: 8'h00};
    osv[0]  = '{psc: 8'd0, cmp: 8'd3};
    osv[1]  = '{psc: 8'd0, cmp: 8'd0};
    osv[2]  = '{psc: 8'd3, cmp: 8'd2};

    // Reset with random bus activity.
    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 2'd0; PWDATA = 8'd0;
    @(negedge PCLK);
    for (int i = 0; i < 6; i++) begin
      rnd = $urandom;
      PSEL = rnd[0]; PENABLE = rnd[1]; PWRITE = rnd[2]; PADDR = rnd[4:3]; PWDATA = rnd[15:8];
      @(negedge PCLK);
    end
    chk("rst count", count, 0);
    chk("rst trig", trig, 0);
    chk("rst irq", irq, 0);
    chk("rst busy", busy, 0);
    chk("rst tick", tick, 0);
    chk("pready", PREADY, 1);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PRESETn = 1'b1;
    @(negedge PCLK);
    for (int i = 0; i < 4; i++) apb_read(i[1:0], 8'h00, $sformatf("rst reg%0d", i));

    // Register write/readback table.
    for (int i = 0; i < 5; i++) begin
      apb_write(regv[i].addr, regv[i].wdata);
      apb_read(regv[i].addr, regv[i].rexp, $sformatf("regvec%0d", i));
    end

    // One-shot table: first trig at commit + 1 + (cmp+1)*(psc+1).
    for (int i = 0; i < 3; i++) begin
      apb_write(2'd2, osv[i].psc);
      apb_write(2'd1, osv[i].cmp);
      tick_cnt = 0;
      trig_obs.delete();
      apb_write(2'd0, 8'h01);
      c0 = last_commit;
      trig_exp.push_back(c0 + 1 + (int'(osv[i].cmp) + 1) * (int'(osv[i].psc) + 1));
      wait_cyc(c0 + 4 + (int'(osv[i].cmp) + 1) * (int'(osv[i].psc) + 1));
      compare_trigs($sformatf("oneshot%0d", i));
      chk($sformatf("oneshot%0d count", i), count, osv[i].cmp);
      chk($sformatf("oneshot%0d busy", i), busy, 0);
      chk($sformatf("oneshot%0d ticks", i), tick_cnt, int'(osv[i].cmp) + 1);
      apb_read(2'd0, 8'h00, $sformatf("oneshot%0d ctrl", i));
      apb_read(2'd3, 8'h01, $sformatf("oneshot%0d status", i));
      apb_write(2'd3, 8'h01);
      apb_read(2'd3, 8'h00, $sformatf("oneshot%0d status w1c", i));
    end

    // Periodic with interrupt, shadow COMPARE update, W1C collision, EN clear on expiry.
    apb_write(2'd2, 8'd2);
    apb_write(2'd1, 8'd1);
    apb_write(2'd0, 8'h07);
    c0 = last_commit;
    trig_exp.push_back(c0 + 7);
    trig_exp.push_back(c0 + 13);
    trig_exp.push_back(c0 + 19);
    trig_exp.push_back(c0 + 34);
    trig_exp.push_back(c0 + 49);
    chk("per busy start", busy, 1);
    wait_cyc(c0 + 6);
    chk("per irq before trig", irq, 0);
    wait_cyc(c0 + 8);
    chk("per irq after trig", irq, 1);
    wait_cyc(c0 + 13);
    apb_write(2'd3, 8'h01);
    chk("per w1c drops irq", irq, 0);
    apb_write(2'd1, 8'd4);
    wait_cyc(c0 + 18);
    apb_write(2'd3, 8'h01);
    chk("per w1c after trig3", irq, 0);
    wait_cyc(c0 + 32);
    apb_write(2'd3, 8'h01);
    chk("collision exp wins", irq, 1);
    apb_read(2'd3, 8'h03, "collision status");
    wait_cyc(c0 + 47);
    apb_write(2'd0, 8'h06);
    wait_cyc(c0 + 50);
    chk("en clear on expiry busy", busy, 0);
    wait_cyc(c0 + 60);
    compare_trigs("periodic");
    apb_read(2'd0, 8'h06, "periodic ctrl after");

    // Abort mid-count.
    apb_write(2'd3, 8'h01);
    apb_write(2'd2, 8'd1);
    apb_write(2'd1, 8'd10);
    trig_obs.delete();
    apb_write(2'd0, 8'h01);
    c0 = last_commit;
    wait_cyc(c0 + 4);
    chk("abort busy running", busy, 1);
    wait_cyc(c0 + 6);
    apb_write(2'd0, 8'h00);
    chk("abort count at clear", count, 3);
    wait_cyc(c0 + 9);
    chk("abort busy falls", busy, 0);
    wait_cyc(c0 + 14);
    chk("abort count holds", count, 3);
    chk("abort no trig", trig_obs.size(), 0);

    // Reset during RUN.
    apb_write(2'd2, 8'd0);
    apb_write(2'd1, 8'd2);
    apb_write(2'd0, 8'h07);
    c0 = last_commit;
    wait_cyc(c0 + 5);
    chk("midrst irq before", irq, 1);
    chk("midrst busy before", busy, 1);
    PRESETn = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    chk("midrst count", count, 0);
    chk("midrst trig", trig, 0);
    chk("midrst irq", irq, 0);
    chk("midrst busy", busy, 0);
    chk("midrst tick", tick, 0);
    trig_obs.delete();
    for (int i = 0; i < 4; i++) apb_read(i[1:0], 8'h00, $sformatf("midrst reg%0d", i));
    wait_cyc(cyc + 5);
    chk("midrst stays idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
